// File: rtl/raster_sched.sv
// Command scheduler: FIFO-buffered DRAW/CLEAR/SWAP sequencing, rasterizer handshake,
// framebuffer write-port mux and clear engine. Optional counters under SCHED_STATS_EN.
module raster_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_WORDS   = 76800
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [229:0] cmd_data,
  output logic [229:0] desc,
  output logic         rast_start,
  input  logic         rast_done,
  input  logic         ras_we,
  input  logic [16:0]  ras_addr,
  input  logic [7:0]   ras_data,
  output logic         fb_we,
  output logic [16:0]  fb_addr,
  output logic [7:0]   fb_data,
  output logic         zclr_we,
  output logic [16:0]  zclr_addr,
  output logic [7:0]   zclr_data,
  input  logic         vsync,
  output logic         front_sel,
  output logic         busy
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]  tri_count,
  output logic [31:0]  frame_cycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [16:0] LAST_ADDR = 17'(FB_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT_DONE,
    S_CLEAR,
    S_SWAP_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [231:0] mem_q [FIFO_DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [229:0] desc_q, desc_d;
  logic [16:0]  addr_q, addr_d;
  logic [7:0]   color_q, color_d;
  logic         front_sel_q, front_sel_d;

  logic         fifo_empty, fifo_full, push, pop;
  logic [231:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push = cmd_valid && !fifo_full;
  assign pop  = (state_q == S_IDLE) && !fifo_empty;
  assign head = mem_q[rd_ptr_q[AW-1:0]];

`ifdef SCHED_STATS_EN
  logic [15:0] tri_count_q, tri_count_d;
  logic [31:0] frame_cycles_q, frame_cycles_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      desc_q      <= '0;
      addr_q      <= '0;
      color_q     <= '0;
      front_sel_q <= 1'b0;
`ifdef SCHED_STATS_EN
      tri_count_q    <= '0;
      frame_cycles_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      desc_q      <= desc_d;
      addr_q      <= addr_d;
      color_q     <= color_d;
      front_sel_q <= front_sel_d;
`ifdef SCHED_STATS_EN
      tri_count_q    <= tri_count_d;
      frame_cycles_q <= frame_cycles_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_data};
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    desc_d      = desc_q;
    addr_d      = addr_q;
    color_d     = color_q;
    front_sel_d = front_sel_q;
    case (state_q)
      S_IDLE: begin
        // Reserved op is popped with no state change, which drops it.
        if (pop) begin
          case (head[231:230])
            2'd0: begin
              desc_d  = head[229:0];
              state_d = S_DISPATCH;
            end
            2'd1: begin
              color_d = head[7:0];
              addr_d  = '0;
              state_d = S_CLEAR;
            end
            2'd2:    state_d = S_SWAP_WAIT;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_DISPATCH:  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (rast_done) state_d = S_IDLE;
      S_CLEAR: begin
        if (addr_q == LAST_ADDR) state_d = S_IDLE;
        else                     addr_d  = addr_q + 17'd1;
      end
      S_SWAP_WAIT: begin
        if (vsync) begin
          front_sel_d = !front_sel_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SCHED_STATS_EN
  always_comb begin
    tri_count_d    = tri_count_q;
    frame_cycles_d = frame_cycles_q;
    if (state_q == S_WAIT_DONE && rast_done) tri_count_d = tri_count_q + 16'd1;
    if (pop && head[231:230] == 2'd1)        tri_count_d = '0;
    if (state_q == S_SWAP_WAIT && vsync)     frame_cycles_d = '0;
    else if (frame_cycles_q != '1)           frame_cycles_d = frame_cycles_q + 32'd1;
  end
  assign tri_count    = tri_count_q;
  assign frame_cycles = frame_cycles_q;
`endif

  always_comb begin
    rast_start = (state_q == S_DISPATCH);
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = '0;
    zclr_we    = 1'b0;
    zclr_addr  = '0;
    case (state_q)
      S_WAIT_DONE: begin
        fb_we   = ras_we;
        fb_addr = ras_addr;
        fb_data = ras_data;
      end
      S_CLEAR: begin
        fb_we     = 1'b1;
        fb_addr   = addr_q;
        fb_data   = color_q;
        zclr_we   = 1'b1;
        zclr_addr = addr_q;
      end
      default: ;
    endcase
  end

  assign zclr_data = 8'hFF;
  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign desc      = desc_q;
  assign front_sel = front_sel_q;

endmodule
